// File: rtl/move_conditioner_if.sv
// Button/frame inputs and move outputs of the move conditioner.
// The game side drives the master modport; the conditioner uses the slave modport.
interface move_conditioner_if;
    logic       i_btn;
    logic       i_frame_start;
    logic       i_clr;
    logic       o_move;
    logic       o_btn_level;
    logic [7:0] o_moves;

    modport master (
        output i_btn, i_frame_start, i_clr,
        input  o_move, o_btn_level, o_moves
    );

    modport slave (
        input  i_btn, i_frame_start, i_clr,
        output o_move, o_btn_level, o_moves
    );
endinterface

// File: rtl/move_conditioner.sv
// Purpose: synchronize/debounce the move button and issue one frame-aligned move strobe per press, plus a saturating move count.
// Latency: o_move one cycle after the qualifying i_frame_start; the button reaches the FSM two cycles late.
// Backpressure: none; at most one move is held pending, and extra presses merge. Macro MOVE_AUTOREPEAT_EN adds hold-to-repeat.
module move_conditioner #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W           = 18
`ifdef MOVE_AUTOREPEAT_EN
    ,
    parameter int REPEAT_FRAMES   = 15
`endif
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    move_conditioner_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESS_CHK = 2'd1,
        HELD      = 2'd2,
        REL_CHK   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             level_q, level_d;
    logic             pending_q, pending_d;
    logic             move_q, move_d;
    logic [7:0]       moves_q, moves_d;
    logic             accept;
    logic             rep;
    logic             issue;

    always_comb begin
        sync1_d = bus.i_btn;
        sync2_d = sync1_q;
    end

    // Debounce FSM; the stability counter restarts on every state change.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (sync2_q) begin
                    state_d = PRESS_CHK;
                    cnt_d   = '0;
                end
            end
            PRESS_CHK: begin
                if (!sync2_q) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = HELD;
                    cnt_d   = '0;
                    accept  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HELD: begin
                if (!sync2_q) begin
                    state_d = REL_CHK;
                    cnt_d   = '0;
                end
            end
            REL_CHK: begin
                if (sync2_q) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        level_d = (state_d == HELD) || (state_d == REL_CHK);
    end

`ifdef MOVE_AUTOREPEAT_EN
    localparam int                FCNT_W    = $clog2(REPEAT_FRAMES + 1);
    localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(REPEAT_FRAMES - 1);

    logic [FCNT_W-1:0] fcnt_q, fcnt_d;

    // Frames counted while held; a repeat only arms pending, so it goes out on the following frame.
    always_comb begin
        fcnt_d = fcnt_q;
        rep    = 1'b0;
        if (bus.i_clr || accept || ((state_d == IDLE) && (state_q != IDLE))) begin
            fcnt_d = '0;
        end else if ((state_q == HELD) && bus.i_frame_start) begin
            if (fcnt_q == FCNT_LAST) begin
                fcnt_d = '0;
                rep    = 1'b1;
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            fcnt_q <= '0;
        end else begin
            fcnt_q <= fcnt_d;
        end
    end
`else
    assign rep = 1'b0;
`endif

    // An accept landing on a frame start is issued on that same frame.
    always_comb begin
        issue     = bus.i_frame_start && (pending_q || accept);
        move_d    = 1'b0;
        pending_d = pending_q;
        moves_d   = moves_q;
        if (bus.i_clr) begin
            pending_d = 1'b0;
            moves_d   = 8'd0;
        end else if (issue) begin
            move_d    = 1'b1;
            pending_d = rep;
            if (moves_q != 8'hFF) begin
                moves_d = moves_q + 8'd1;
            end
        end else begin
            pending_d = pending_q || accept || rep;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            state_q   <= IDLE;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            pending_q <= 1'b0;
            move_q    <= 1'b0;
            moves_q   <= 8'd0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            pending_q <= pending_d;
            move_q    <= move_d;
            moves_q   <= moves_d;
        end
    end

    assign bus.o_move      = move_q;
    assign bus.o_btn_level = level_q;
    assign bus.o_moves     = moves_q;

endmodule
